simple_proc_core: RTL and testbench

- Parametrised successor to the four-register A/G/ALU processor datapath.
- Integrates four things in one clocked block:
  - a register file of NREGS x WIDTH;
  - accumulator A and result register G;
  - an add/sub unit;
  - a control FSM that executes LOAD/MOVE/ADD/SUB.
- The shared bus is a registered-select mux (no internal tri-states).
- Instructions arrive through a run/done handshake from the top-level test harness or a future sequencer.

---
 rtl/simple_proc_pkg.sv | 41 ++++
 rtl/proc_addsub.sv | 27 ++
 rtl/simple_proc_core.sv | 186 ++++++++++++++++++
 tb/tb_simple_proc_core.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_proc_pkg.sv
// ============================================================================
// Module  : simple_proc_pkg
// Brief   : Opcodes, FSM state encoding and bus-select codes for simple_proc_core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package simple_proc_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_T1   = ST_T1,
    S_T2   = ST_T2,
    S_T3   = ST_T3,
    S_DONE = ST_DONE
  } state_t;

  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_DIN  = 2'd1;
  localparam logic [1:0] SEL_REG  = 2'd2;
  localparam logic [1:0] SEL_G    = 2'd3;

  // ADD and SUB share the three-step A/G path; both have op[1] set.
  function automatic logic is_arith(input logic [1:0] op_i);
    return op_i[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/proc_addsub.sv
// ============================================================================
// Module  : proc_addsub
// Brief   : Combinational two's-complement add/sub with signed-overflow flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module proc_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_res,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b_eff;

  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign o_res   = i_a + w_b_eff + {{(WIDTH-1){1'b0}}, i_sub};
  // Overflow: operands share a sign that the result does not.
  assign o_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_res[WIDTH-1] != i_a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/simple_proc_core.sv
// ============================================================================
// Module  : simple_proc_core
// Brief   : Register file + A/G accumulator datapath with LOAD/MOVE/ADD/SUB FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module simple_proc_core
  import simple_proc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int IDX_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [1:0]       op,
  input  logic [IDX_W-1:0] rx,
  input  logic [IDX_W-1:0] ry,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [WIDTH-1:0] bus,
  input  logic [IDX_W-1:0] rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [1:0]       r_op;
  logic [IDX_W-1:0] r_rx;
  logic [IDX_W-1:0] r_ry;
  logic [WIDTH-1:0] r_din;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_g;
  logic             r_ovf;
  logic [WIDTH-1:0] r_regs [NREGS];

  logic [1:0]       r_bus_sel;
  logic [IDX_W-1:0] r_bus_idx;
  logic [1:0]       w_bus_sel_nxt;
  logic [IDX_W-1:0] w_bus_idx_nxt;

  logic             w_accept;
  logic [1:0]       w_op_nxt;
  logic [IDX_W-1:0] w_rx_nxt;
  logic [IDX_W-1:0] w_ry_nxt;

  logic [WIDTH-1:0] w_bus;
  logic [WIDTH-1:0] w_reg_rd;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_we;
  logic             w_load_a;
  logic             w_load_g;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  assign w_accept = (r_state == S_IDLE) && run;
  assign w_op_nxt = w_accept ? op : r_op;
  assign w_rx_nxt = w_accept ? rx : r_rx;
  assign w_ry_nxt = w_accept ? ry : r_ry;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (run) w_state_nxt = S_T1;
      S_T1:    w_state_nxt = is_arith(r_op) ? S_T2 : S_DONE;
      S_T2:    w_state_nxt = S_T3;
      S_T3:    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus source is chosen one cycle ahead from the next state and registered
  // with it, so the bus mux is driven purely by flops.
  always_comb begin
    w_bus_sel_nxt = SEL_ZERO;
    w_bus_idx_nxt = '0;
    case (w_state_nxt)
      S_T1: begin
        if (w_op_nxt == OP_LOAD) begin
          w_bus_sel_nxt = SEL_DIN;
        end else if (w_op_nxt == OP_MOVE) begin
          w_bus_sel_nxt = SEL_REG;
          w_bus_idx_nxt = w_ry_nxt;
        end else begin
          w_bus_sel_nxt = SEL_REG;
          w_bus_idx_nxt = w_rx_nxt;
        end
      end
      S_T2: begin
        w_bus_sel_nxt = SEL_REG;
        w_bus_idx_nxt = w_ry_nxt;
      end
      S_T3:    w_bus_sel_nxt = SEL_G;
      default: w_bus_sel_nxt = SEL_ZERO;
    endcase
  end

  // Indices with no backing register read as zero.
  always_comb begin
    w_reg_rd  = '0;
    w_rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (r_bus_idx == IDX_W'(i)) w_reg_rd  = r_regs[i];
      if (rd_sel    == IDX_W'(i)) w_rd_data = r_regs[i];
    end
  end

  always_comb begin
    case (r_bus_sel)
      SEL_DIN: w_bus = r_din;
      SEL_REG: w_bus = w_reg_rd;
      SEL_G:   w_bus = r_g;
      default: w_bus = '0;
    endcase
  end

  assign w_we     = ((r_state == S_T1) && !is_arith(r_op)) || (r_state == S_T3);
  assign w_load_a = (r_state == S_T1) && is_arith(r_op);
  assign w_load_g = (r_state == S_T2);

  proc_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_a   (r_a),
    .i_b   (w_bus),
    .i_sub (r_op == OP_SUB),
    .o_res (w_sum),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_bus_sel <= SEL_ZERO;
      r_bus_idx <= '0;
      r_op      <= '0;
      r_rx      <= '0;
      r_ry      <= '0;
      r_din     <= '0;
      r_a       <= '0;
      r_g       <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bus_sel <= w_bus_sel_nxt;
      r_bus_idx <= w_bus_idx_nxt;
      if (w_accept) begin
        r_op  <= op;
        r_rx  <= rx;
        r_ry  <= ry;
        r_din <= din;
      end
      if (w_load_a) r_a <= w_bus;
      if (w_load_g) begin
        r_g   <= w_sum;
        r_ovf <= w_ovf;
      end
    end
  end

  // Out-of-range destinations match no entry, so the write is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_we && (r_rx == IDX_W'(i))) r_regs[i] <= w_bus;
      end
    end
  end

  assign busy    = (r_state == S_T1) || (r_state == S_T2) || (r_state == S_T3);
  assign done    = (r_state == S_DONE);
  assign ovf     = r_ovf;
  assign bus     = w_bus;
  assign rd_data = w_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_simple_proc_core.sv
// ============================================================================
// Module  : tb_simple_proc_core
// Brief   : Scoreboard bench for simple_proc_core (WIDTH=16, NREGS=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_simple_proc_core;
  import simple_proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [1:0]  op;
  logic [1:0]  rx;
  logic [1:0]  ry;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bus;
  logic [15:0] rd_data;
  logic [1:0]  rd_sel;
  logic [1:0]  stim_sel = 2'd0;
  logic [1:0]  mon_sel = 2'd0;
  logic        mon_active = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  rx;
    logic [15:0] val;
    logic        ovf;
    logic [15:0] b0;
    logic [15:0] b1;
    logic [15:0] b2;
    int          nbus;
    int          lat;
    int          acc;
  } item_t;

  item_t       sb[$];
  logic [15:0] obs[$];
  logic [15:0] model_r [4];
  logic        model_ovf;

  assign rd_sel = mon_active ? mon_sel : stim_sel;

  simple_proc_core #(
    .WIDTH (16),
    .NREGS (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .op      (op),
    .rx      (rx),
    .ry      (ry),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bus     (bus),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model works on whole-instruction semantics: signed integer arithmetic
  // decides overflow, truncation to 16 bits gives the wrapped result.
  task automatic issue(input logic [1:0] o, input logic [1:0] x, input logic [1:0] y,
                       input logic [15:0] d, input bit hold, output int acc);
    item_t       it;
    int          w;
    int          sa;
    int          sbv;
    int          res_i;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    w = 0;
    @(negedge clk);
    while (!(busy == 1'b0 && done == 1'b0) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      check("idle_timeout", 32'd1, 32'd0);
      acc = -1;
      return;
    end
    op = o; rx = x; ry = y; din = d; run = 1'b1;
    it.op = o; it.rx = x; it.b0 = '0; it.b1 = '0; it.b2 = '0;
    if (o == OP_LOAD) begin
      it.b0 = d; model_r[x] = d; it.nbus = 1; it.lat = 2;
    end else if (o == OP_MOVE) begin
      it.b0 = model_r[y]; model_r[x] = model_r[y]; it.nbus = 1; it.lat = 2;
    end else begin
      a = model_r[x];
      b = model_r[y];
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      res_i = (o == OP_ADD) ? (sa + sbv) : (sa - sbv);
      model_ovf = (res_i > 32767) || (res_i < -32768);
      r = res_i[15:0];
      model_r[x] = r;
      it.b0 = a; it.b1 = b; it.b2 = r; it.nbus = 3; it.lat = 4;
    end
    it.val = model_r[x];
    it.ovf = model_ovf;
    @(posedge clk);
    #1;
    acc = cyc;
    it.acc = acc;
    sb.push_back(it);
    if (!hold) run = 1'b0;
  endtask

  always @(negedge clk) begin
    item_t       it;
    logic [15:0] expb [3];
    if (!rst) begin
      obs.delete();
    end else begin
      if (busy) obs.push_back(bus);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          it = sb.pop_front();
          expb[0] = it.b0; expb[1] = it.b1; expb[2] = it.b2;
          check("latency", 32'(cyc - it.acc + 1), 32'(it.lat));
          check("done_busy", {31'd0, busy}, 32'd0);
          check("done_bus", {16'd0, bus}, 32'd0);
          check("ovf", {31'd0, ovf}, {31'd0, it.ovf});
          check("bus_count", 32'(obs.size()), 32'(it.nbus));
          for (int i = 0; i < it.nbus && i < obs.size(); i++)
            check($sformatf("bus_seq[%0d]", i), {16'd0, obs[i]}, {16'd0, expb[i]});
          mon_sel = it.rx;
          mon_active = 1'b1;
          #1;
          check($sformatf("rd_data_R%0d", it.rx), {16'd0, rd_data}, {16'd0, it.val});
          mon_active = 1'b0;
        end
        obs.delete();
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pick_data();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int a1, a2, a3, w;
    rst = 1'b0; run = 1'b0; op = '0; rx = '0; ry = '0; din = '0;
    for (int i = 0; i < 4; i++) model_r[i] = '0;
    model_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    check("rst_bus",  {16'd0, bus},  32'd0);
    check("rst_rd_R0", {16'd0, rd_data}, 32'd0);
    rst = 1'b1;

    issue(OP_LOAD, 2'd0, 2'd0, 16'h0005, 1'b0, a1);
    issue(OP_LOAD, 2'd1, 2'd0, 16'h0003, 1'b0, a1);
    issue(OP_ADD,  2'd0, 2'd1, 16'h0000, 1'b0, a1);
    issue(OP_LOAD, 2'd2, 2'd0, 16'h7FFF, 1'b0, a1);
    issue(OP_LOAD, 2'd3, 2'd0, 16'h0001, 1'b0, a1);
    issue(OP_ADD,  2'd2, 2'd3, 16'h0000, 1'b0, a1);
    issue(OP_SUB,  2'd3, 2'd3, 16'h0000, 1'b0, a1);

    issue(OP_MOVE, 2'd1, 2'd2, 16'h1234, 1'b1, a1);
    issue(OP_MOVE, 2'd0, 2'd2, 16'h2345, 1'b1, a2);
    check("b2b_gap_1", 32'(a2 - a1), 32'd3);
    issue(OP_MOVE, 2'd1, 2'd1, 16'h3456, 1'b1, a3);
    check("b2b_gap_2", 32'(a3 - a2), 32'd3);
    run = 1'b0;

    // A run pulse mid-instruction must be neither executed nor queued.
    issue(OP_ADD, 2'd0, 2'd1, 16'h0000, 1'b0, a1);
    @(negedge clk);
    run = 1'b1; op = OP_LOAD; rx = 2'd0; din = 16'hFFFF;
    @(negedge clk);
    run = 1'b0;

    for (int n = 0; n < 40; n++) begin
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            pick_data(), ($urandom_range(0, 3) == 0), a1);
    end
    run = 1'b0;

    // Abort a SUB in T2 with ovf set and registers non-zero.
    issue(OP_LOAD, 2'd0, 2'd0, 16'h7FFF, 1'b0, a1);
    issue(OP_ADD,  2'd0, 2'd0, 16'h0000, 1'b0, a1);
    issue(OP_LOAD, 2'd1, 2'd0, 16'h1111, 1'b0, a1);
    issue(OP_SUB,  2'd0, 2'd1, 16'h0000, 1'b0, a1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ovf",  {31'd0, ovf},  32'd0);
    check("abort_bus",  {16'd0, bus},  32'd0);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    for (int i = 0; i < 4; i++) model_r[i] = '0;
    model_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stim_sel = 2'(i);
      #1;
      check($sformatf("post_rst_R%0d", i), {16'd0, rd_data}, 32'd0);
    end
    repeat (8) @(negedge clk);
    issue(OP_LOAD, 2'd3, 2'd0, 16'hBEEF, 1'b0, a1);
    issue(OP_SUB,  2'd2, 2'd3, 16'h0000, 1'b0, a1);

    w = 0;
    while (sb.size() > 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
